// File: rtl/bitslip_align_ctrl.sv
// bitslip_align_ctrl
// Trains a bitslip_shift instance on a known frame/training word.
// bitslip_count is stepped through every offset once per training run.
// At each offset the lane is given time to settle. The realigned word is
// then compared against TRAIN_PATTERN. A run of MATCH_COUNT consecutive
// matches declares lock. While locked, MISS_LIMIT consecutive misses drop
// lock and start a new training run automatically.
//
// Ports:
//   clk           sole clock; frame_data is synchronous to it
//   rst_n         asynchronous, active-low reset
//   start         training request, sampled every cycle
//   frame_data    realigned word from bitslip_shift (dout)
//   bitslip_count slip offset driven into bitslip_shift
//   busy          high while searching (SETTLE/CHECK/NEXT)
//   locked        high only while locked
//   fail          high after a full sweep found no matching offset
//   lock_lost     one-cycle pulse when lock is dropped because of misses
module bitslip_align_ctrl #(
   parameter int                   DIN_WIDTH     = 8,
   parameter logic [DIN_WIDTH-1:0] TRAIN_PATTERN = DIN_WIDTH'(8'hF0),
   parameter int                   SETTLE_CYCLES = 4,
   parameter int                   MATCH_COUNT   = 16,
   parameter int                   MISS_LIMIT    = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic [DIN_WIDTH-1:0]         frame_data,
   output logic [$clog2(DIN_WIDTH)-1:0] bitslip_count,
   output logic                         busy,
   output logic                         locked,
   output logic                         fail,
   output logic                         lock_lost
);

   localparam int CW = $clog2(DIN_WIDTH);
   localparam int SW = $clog2(SETTLE_CYCLES + 1);
   localparam int MW = $clog2(MATCH_COUNT + 1);
   localparam int XW = $clog2(MISS_LIMIT + 1);

   typedef enum logic [2:0] {
      IDLE,
      SETTLE,
      CHECK,
      NEXT,
      LOCKED,
      FAIL
   } state_t;

   state_t          state, state_nx;
   logic [CW-1:0]   count_nx;
   logic [SW-1:0]   settle_cnt, settle_nx;
   logic [MW-1:0]   match_cnt, match_nx;
   logic [XW-1:0]   miss_cnt, miss_nx;
   logic            lost_nx;
   logic            is_match;

   assign is_match = (frame_data == TRAIN_PATTERN);

   // State, counters and outputs are all registered. The status flags are
   // decoded from the next state so they line up with the state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         bitslip_count <= '0;
         settle_cnt    <= '0;
         match_cnt     <= '0;
         miss_cnt      <= '0;
         busy          <= 1'b0;
         locked        <= 1'b0;
         fail          <= 1'b0;
         lock_lost     <= 1'b0;
      end else begin
         state         <= state_nx;
         bitslip_count <= count_nx;
         settle_cnt    <= settle_nx;
         match_cnt     <= match_nx;
         miss_cnt      <= miss_nx;
         busy          <= (state_nx == SETTLE) || (state_nx == CHECK) || (state_nx == NEXT);
         locked        <= (state_nx == LOCKED);
         fail          <= (state_nx == FAIL);
         lock_lost     <= lost_nx;
      end
   end

   // Next-state and counter logic. start only matters in IDLE, LOCKED and
   // FAIL, so a held start cannot disturb a sweep already in progress. In
   // LOCKED a start beats a simultaneous final miss, which is why it is
   // tested first and suppresses the lock_lost pulse.
   always_comb begin
      state_nx  = state;
      count_nx  = bitslip_count;
      settle_nx = settle_cnt;
      match_nx  = match_cnt;
      miss_nx   = miss_cnt;
      lost_nx   = 1'b0;

      case (state)
         IDLE: begin
            if (start) begin
               state_nx  = SETTLE;
               count_nx  = '0;
               settle_nx = '0;
            end
         end

         SETTLE: begin
            if (settle_cnt == SW'(SETTLE_CYCLES - 1)) begin
               state_nx  = CHECK;
               settle_nx = '0;
               match_nx  = '0;
            end else begin
               settle_nx = settle_cnt + 1'b1;
            end
         end

         CHECK: begin
            if (is_match) begin
               if (match_cnt == MW'(MATCH_COUNT - 1)) begin
                  state_nx = LOCKED;
                  match_nx = MW'(MATCH_COUNT);
                  miss_nx  = '0;
               end else begin
                  match_nx = match_cnt + 1'b1;
               end
            end else begin
               state_nx = NEXT;
               match_nx = '0;
            end
         end

         NEXT: begin
            // The sweep never wraps: the last offset ends the run in FAIL.
            if (bitslip_count == CW'(DIN_WIDTH - 1)) begin
               state_nx = FAIL;
            end else begin
               state_nx  = SETTLE;
               count_nx  = bitslip_count + 1'b1;
               settle_nx = '0;
            end
         end

         LOCKED: begin
            if (start) begin
               state_nx  = SETTLE;
               count_nx  = '0;
               settle_nx = '0;
               miss_nx   = '0;
            end else if (is_match) begin
               miss_nx = '0;
            end else if (miss_cnt == XW'(MISS_LIMIT - 1)) begin
               state_nx  = SETTLE;
               count_nx  = '0;
               settle_nx = '0;
               miss_nx   = '0;
               lost_nx   = 1'b1;
            end else begin
               miss_nx = miss_cnt + 1'b1;
            end
         end

         FAIL: begin
            if (start) begin
               state_nx  = SETTLE;
               count_nx  = '0;
               settle_nx = '0;
            end
         end

         default: begin
            state_nx = IDLE;
            count_nx = '0;
         end
      endcase
   end

endmodule

// File: doc/bitslip_align_ctrl.md
Name: bitslip_align_ctrl

Overview:
Sequencer that trains a bitslip_shift instance on an ADC frame/training word. It steps bitslip_count through every offset and checks the realigned word against a known pattern. It declares lock after a run of consecutive matches, then monitors lock and re-trains if lock is lost. One instance sits beside each deserialized lane, between the lane's bitslip_shift output and the lane-status registers.

Parameters:
DIN_WIDTH, 8, word width. Must be a power of two and at least 2. Must match the bitslip_shift instance.
TRAIN_PATTERN, 8'hF0, expected aligned word (DIN_WIDTH bits).
SETTLE_CYCLES, 4, cycles ignored after any bitslip_count change. Must be at least 3, to cover the 2-stage bitslip_shift pipeline.
MATCH_COUNT, 16, consecutive matches required to declare lock. Must be at least 1.
MISS_LIMIT, 4, consecutive mismatches in LOCKED that drop lock. Must be at least 1.

Ports:
clk  in  1  sole clock; frame_data is synchronous to it
rst_n  in  1  asynchronous, active-low reset
start  in  1  request training (level sampled per cycle)
frame_data  in  DIN_WIDTH  dout of bitslip_shift
bitslip_count  out  $clog2(DIN_WIDTH)  drives bitslip_shift.bitslip_count
busy  out  1  high during a search (SETTLE/CHECK/NEXT)
locked  out  1  high only in LOCKED
fail  out  1  high in FAIL; full sweep found no offset
lock_lost  out  1  one-cycle pulse when LOCKED exits because of misses

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, bitslip_count=0, all counters=0, busy=locked=fail=lock_lost=0. Reset mid-search aborts immediately with no residual state.
- All outputs are registered and change only on clk rising edges.
- FSM states: IDLE, SETTLE, CHECK, NEXT, LOCKED, FAIL.
- IDLE:
  - start=1 → SETTLE, bitslip_count=0, settle_cnt=0.
- SETTLE:
  - settle_cnt increments each cycle.
  - When settle_cnt==SETTLE_CYCLES-1 → CHECK, match_cnt=0.
  - frame_data is ignored in this state.
- CHECK:
  - frame_data==TRAIN_PATTERN → match_cnt+1.
  - When the incremented value equals MATCH_COUNT → LOCKED, miss_cnt=0.
  - Any mismatch → NEXT, regardless of match_cnt.
- NEXT (one cycle):
  - If bitslip_count==DIN_WIDTH-1 → FAIL, and bitslip_count holds its value.
  - Else bitslip_count+1 → SETTLE, settle_cnt=0.
  - No wrap-around within one sweep: each offset is tried exactly once per start.
- LOCKED:
  - bitslip_count is frozen.
  - A match clears miss_cnt. A mismatch increments miss_cnt.
  - When miss_cnt reaches MISS_LIMIT → assert lock_lost for exactly 1 cycle, then go to SETTLE with bitslip_count=0 (automatic re-train, busy=1).
  - start=1 in LOCKED → SETTLE with bitslip_count=0 and no lock_lost pulse.
- FAIL:
  - fail is held high.
  - start=1 → SETTLE with bitslip_count=0, and fail drops.
  - Otherwise the block stays in FAIL.
- start is ignored in SETTLE, CHECK and NEXT.
- Simultaneous events:
  - In LOCKED, start=1 in the same cycle as the MISS_LIMIT-th miss → start wins, and lock_lost is not pulsed.
  - In CHECK, the final matching sample moves the FSM to LOCKED. The next cycle's data is evaluated under LOCKED rules.
- Output decode:
  - busy = state in {SETTLE, CHECK, NEXT}.
  - locked = (state==LOCKED).
  - fail = (state==FAIL).
  - busy, locked and fail are mutually exclusive.
- Counter widths:
  - settle_cnt: $clog2(SETTLE_CYCLES+1).
  - match_cnt: $clog2(MATCH_COUNT+1).
  - miss_cnt: $clog2(MISS_LIMIT+1).
  - Counters never wrap.
- Timing: cost per rejected offset is SETTLE_CYCLES + (cycles in CHECK) + 1.
- Lock-time bound for a clean lane aligned at offset k, measured from the start-sampling edge: lock within k*(SETTLE_CYCLES+MATCH_COUNT+1) + SETTLE_CYCLES + MATCH_COUNT + 1 cycles.

Test Plan:
Bench setup for all scenarios: serializer model feeding a real bitslip_shift with a configurable phase, whose dout drives frame_data. Defaults apply (DIN_WIDTH=8, pattern 8'hF0, SETTLE_CYCLES=4, MATCH_COUNT=16, MISS_LIMIT=4).
1. Reset/idle: assert rst_n=0 mid-CHECK at offset 3 → same cycle, all outputs 0 and bitslip_count=0. With rst_n=1 and no start → stays IDLE indefinitely.
2. Clean lock: lane phase needs offset 5, pulse start → busy=1, bitslip_count sweeps 0..5. Then locked=1 with bitslip_count=5, no later than 5*21+21 = 126 cycles after start. busy=0 and fail=0 thereafter.
3. Intermittent match: at offset 2, inject 15 matches then 1 mismatch → FSM advances to offset 3 (no lock at 2). The lane locks at its true offset 6.
4. Lock loss: after lock at 5, force 3 mismatches then 1 match → stays locked. Then force 4 consecutive mismatches → single-cycle lock_lost, locked=0, busy=1, bitslip_count=0, and the block re-locks at 5.
5. No pattern: frame_data held at 8'h00, pulse start → visits offsets 0..7 once, then fail=1 with bitslip_count=7. A further start clears fail and re-sweeps.
6. Start handling: start held high during the search → no restart (monotonic offsets). start coinciding with the 4th miss in LOCKED → no lock_lost pulse, SETTLE at offset 0.
